// File: rtl/bus_address_decoder.sv
// bus_address_decoder
//   Registered slave-select decoder for the UART peripheral bus. A master
//   request is latched in IDLE. The decoder then drives a held one-hot select
//   to the addressed slave and waits for that slave's acknowledge. Each
//   request ends in one completion pulse. Out-of-range addresses and slaves
//   that do not answer within TIMEOUT cycles produce a bus-error pulse.
//
// Ports
//   clk            system clock, rising edge
//   resetN         asynchronous active-low reset
//   enable         global enable; gates new requests only
//   reqIn          master request, sampled in IDLE
//   addressIn      slave index, sampled with reqIn
//   writeIn        direction (1 = write), sampled with reqIn
//   slaveAck       per-slave acknowledge; only the selected bit is looked at
//   decodedAddress registered one-hot select, held for the whole access
//   writeOut       registered direction, valid while decodedAddress != 0
//   ackOut         one-cycle completion pulse
//   errorOut       one-cycle bus-error pulse, coincident with ackOut
//   busy           high whenever the FSM is not in IDLE
module bus_address_decoder #(
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_SLAVES = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  enable,
  input  logic                  reqIn,
  input  logic [ADDR_WIDTH-1:0] addressIn,
  input  logic                  writeIn,
  input  logic [NUM_SLAVES-1:0] slaveAck,
  output logic [NUM_SLAVES-1:0] decodedAddress,
  output logic                  writeOut,
  output logic                  ackOut,
  output logic                  errorOut,
  output logic                  busy
);

  // The counter keeps at least one bit so that TIMEOUT = 0 still elaborates.
  // With TIMEOUT = 0 the counter is never used.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  // ADDR_WIDTH <= 8 and NUM_SLAVES <= 256, so 9 bits hold both sides of the
  // range compare without truncation.
  localparam logic [8:0] NUM_SLAVES_W = 9'(NUM_SLAVES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] decoded_q, decoded_d;
  logic                  write_q, write_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0] addr_onehot;
  logic                  addr_in_range;
  logic                  sel_ack;

  // One comparator per select line. An out-of-range address sets no bit.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
    assign addr_onehot[gi] = (addressIn == ADDR_WIDTH'(gi));
  end

  assign addr_in_range = (9'(addressIn) < NUM_SLAVES_W);

  // The held select is one-hot, so masking picks out exactly the selected
  // slave's ack. Acks from other slaves drop out here.
  assign sel_ack = |(slaveAck & decoded_q);

  always_comb begin
    state_d   = state_q;
    decoded_d = decoded_q;
    write_d   = write_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        decoded_d = '0;
        write_d   = 1'b0;
        if (enable && reqIn) begin
          if (addr_in_range) begin
            state_d   = ACCESS;
            decoded_d = addr_onehot;
            write_d   = writeIn;
            cnt_d     = '0;
          end else begin
            // Skip ACCESS entirely. The error pulse covers the ERROR cycle.
            state_d = ERROR;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      ACCESS: begin
        if (sel_ack) begin
          // The ack is tested first, so it beats a timeout on the same edge.
          state_d   = DONE;
          ack_d     = 1'b1;
          decoded_d = '0;
          write_d   = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = ERROR;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          decoded_d = '0;
          write_d   = 1'b0;
        end else if (TIMEOUT != 0) begin
          // The counter never passes CNT_LAST, so it cannot wrap.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE, ERROR: begin
        state_d   = IDLE;
        decoded_d = '0;
        write_d   = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        decoded_d = '0;
        write_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      decoded_q <= '0;
      write_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      decoded_q <= decoded_d;
      write_q   <= write_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign decodedAddress = decoded_q;
  assign writeOut       = write_q;
  assign ackOut         = ack_q;
  assign errorOut       = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_bus_address_decoder.sv
// tb_bus_address_decoder
//   Drives four decoder configurations from shared inputs:
//     0: defaults
//     1: TIMEOUT = 4
//     2: NUM_SLAVES = 6
//     3: TIMEOUT = 2
//   Only the configuration selected by `cur` is monitored. The bench switches
//   `cur` only after every instance has gone idle.
//   When a request is driven, the expected outcome goes into the queue:
//     - error flag
//     - select value
//     - number of select cycles
//     - write flag
//   The monitor pops that entry when ackOut is seen.
module tb_bus_address_decoder;

  logic       clk = 1'b0;
  logic       resetN;
  logic       enable;
  logic       reqIn;
  logic [2:0] addressIn;
  logic       writeIn;
  logic [7:0] slaveAck;

  logic [7:0] dec_v [4];
  logic [5:0] dec_ns6;
  logic [3:0] wr_v, ack_v, err_v, busy_v;

  int         cur;
  logic [7:0] m_dec;
  logic       m_wr, m_ack, m_err, m_busy;

  typedef struct {
    logic       err;
    logic [7:0] sel;
    int         cycles;
    logic       wr;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_address_decoder u_def (
    .clk(clk), .resetN(resetN), .enable(enable), .reqIn(reqIn),
    .addressIn(addressIn), .writeIn(writeIn), .slaveAck(slaveAck),
    .decodedAddress(dec_v[0]), .writeOut(wr_v[0]), .ackOut(ack_v[0]),
    .errorOut(err_v[0]), .busy(busy_v[0])
  );

  bus_address_decoder #(.ADDR_WIDTH(3), .NUM_SLAVES(8), .TIMEOUT(4)) u_t4 (
    .clk(clk), .resetN(resetN), .enable(enable), .reqIn(reqIn),
    .addressIn(addressIn), .writeIn(writeIn), .slaveAck(slaveAck),
    .decodedAddress(dec_v[1]), .writeOut(wr_v[1]), .ackOut(ack_v[1]),
    .errorOut(err_v[1]), .busy(busy_v[1])
  );

  bus_address_decoder #(.ADDR_WIDTH(3), .NUM_SLAVES(6), .TIMEOUT(16)) u_ns6 (
    .clk(clk), .resetN(resetN), .enable(enable), .reqIn(reqIn),
    .addressIn(addressIn), .writeIn(writeIn), .slaveAck(slaveAck[5:0]),
    .decodedAddress(dec_ns6), .writeOut(wr_v[2]), .ackOut(ack_v[2]),
    .errorOut(err_v[2]), .busy(busy_v[2])
  );

  bus_address_decoder #(.ADDR_WIDTH(3), .NUM_SLAVES(8), .TIMEOUT(2)) u_t2 (
    .clk(clk), .resetN(resetN), .enable(enable), .reqIn(reqIn),
    .addressIn(addressIn), .writeIn(writeIn), .slaveAck(slaveAck),
    .decodedAddress(dec_v[3]), .writeOut(wr_v[3]), .ackOut(ack_v[3]),
    .errorOut(err_v[3]), .busy(busy_v[3])
  );

  assign dec_v[2] = {2'b00, dec_ns6};

  assign m_dec  = dec_v[cur];
  assign m_wr   = wr_v[cur];
  assign m_ack  = ack_v[cur];
  assign m_err  = err_v[cur];
  assign m_busy = busy_v[cur];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cfg %0d, t=%0t)", tag, got, exp, cur, $time);
    end
  endtask

  task automatic push_exp(input logic err, input logic [7:0] sel, input int cycles, input logic wr);
    exp_t e;
    e.err    = err;
    e.sel    = sel;
    e.cycles = cycles;
    e.wr     = wr;
    sb.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one request on the next falling edge and records what it should
  // produce.
  task automatic drive_req(input logic [2:0] addr, input logic wr, input logic err,
                           input logic [7:0] sel, input int cycles);
    @(negedge clk);
    reqIn     = 1'b1;
    addressIn = addr;
    writeIn   = wr;
    push_exp(err, sel, cycles, wr & (sel != 8'h00));
    $display("txn cfg=%0d addr=%0d wr=%0d exp_err=%0d exp_sel=0x%02h exp_cycles=%0d",
             cur, addr, wr, err, sel, cycles);
  endtask

  // Transaction monitor. It samples on the falling edge, away from the
  // active edge.
  int         sel_cycles;
  logic [7:0] sel_seen;
  logic       wr_seen;
  logic       prev_ack;

  always @(negedge clk) begin
    if (!resetN) begin
      sel_cycles = 0;
      sel_seen   = 8'h00;
      wr_seen    = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (prev_ack) begin
        check("ack_one_cycle", {31'd0, m_ack}, 32'd0);
        check("busy_after_ack", {31'd0, m_busy}, 32'd0);
      end
      check("onehot", {31'd0, ($countones(m_dec) <= 1)}, 32'd1);
      if (m_dec != 8'h00) begin
        if (sel_cycles == 0) begin
          sel_seen = m_dec;
          wr_seen  = m_wr;
        end else begin
          check("sel_hold", {24'd0, m_dec}, {24'd0, sel_seen});
        end
        sel_cycles++;
      end else begin
        check("wr_without_sel", {31'd0, m_wr}, 32'd0);
      end
      if (m_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {31'd0, m_ack}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("err_flag", {31'd0, m_err}, {31'd0, e.err});
          check("sel_value", {24'd0, sel_seen}, {24'd0, e.sel});
          check("sel_cycles", sel_cycles, e.cycles);
          check("write_out", {31'd0, wr_seen}, {31'd0, e.wr});
        end
        check("sel_clear_at_ack", {24'd0, m_dec}, 32'd0);
        sel_cycles = 0;
        sel_seen   = 8'h00;
        wr_seen    = 1'b0;
      end else begin
        check("err_without_ack", {31'd0, m_err}, 32'd0);
      end
      prev_ack = m_ack;
    end
  end

  initial begin
    resetN    = 1'b0;
    enable    = 1'b0;
    reqIn     = 1'b0;
    addressIn = 3'd0;
    writeIn   = 1'b0;
    slaveAck  = 8'h00;
    cur       = 0;
    #12;
    for (int k = 0; k < 4; k++) begin
      check("rst_dec", {24'd0, dec_v[k]}, 32'd0);
      check("rst_ack", {31'd0, ack_v[k]}, 32'd0);
      check("rst_err", {31'd0, err_v[k]}, 32'd0);
      check("rst_busy", {31'd0, busy_v[k]}, 32'd0);
      check("rst_wr", {31'd0, wr_v[k]}, 32'd0);
    end
    @(negedge clk);
    resetN = 1'b1;
    enable = 1'b1;
    idle_cycles(2);

    // Test 1: each address 0..7 is acked one cycle after its select appears.
    cur = 0;
    for (int a = 0; a < 8; a++) begin
      logic [2:0] a3;
      a3 = 3'(a);
      drive_req(a3, a3[0], 1'b0, 8'h01 << a, 1);
      @(negedge clk);
      reqIn    = 1'b0;
      slaveAck = 8'h01 << a;
      @(negedge clk);
      slaveAck = 8'h00;
      @(negedge clk);
    end
    idle_cycles(20);

    // Test 2: TIMEOUT = 4, address 3, no ack.
    cur = 1;
    drive_req(3'd3, 1'b1, 1'b1, 8'h08, 4);
    @(negedge clk);
    reqIn = 1'b0;
    idle_cycles(20);

    // Test 3: NUM_SLAVES = 6.
    // Addresses 7 and 6 are out of range; 5 is the last legal slave.
    cur = 2;
    drive_req(3'd7, 1'b0, 1'b1, 8'h00, 0);
    @(negedge clk);
    reqIn = 1'b0;
    check("oor7_ack_timing", {31'd0, m_ack}, 32'd1);
    check("oor7_err_timing", {31'd0, m_err}, 32'd1);
    idle_cycles(2);
    drive_req(3'd6, 1'b1, 1'b1, 8'h00, 0);
    @(negedge clk);
    reqIn = 1'b0;
    check("oor6_ack_timing", {31'd0, m_ack}, 32'd1);
    idle_cycles(2);
    drive_req(3'd5, 1'b1, 1'b0, 8'h20, 1);
    @(negedge clk);
    reqIn    = 1'b0;
    slaveAck = 8'h20;
    @(negedge clk);
    slaveAck = 8'h00;
    idle_cycles(20);

    // Test 4: a foreign ack on slave 4 is held throughout.
    // The real ack (slave 2) arrives on the third ACCESS edge.
    cur = 0;
    drive_req(3'd2, 1'b1, 1'b0, 8'h04, 3);
    @(negedge clk);
    reqIn    = 1'b0;
    slaveAck = 8'h10;
    @(negedge clk);
    @(negedge clk);
    slaveAck = 8'h14;
    @(negedge clk);
    slaveAck = 8'h10;
    @(negedge clk);
    slaveAck = 8'h00;
    idle_cycles(20);

    // Test 5a: TIMEOUT = 2.
    // First an ack on the final counting edge, then a plain timeout.
    cur = 3;
    drive_req(3'd1, 1'b0, 1'b0, 8'h02, 2);
    @(negedge clk);
    reqIn = 1'b0;
    @(negedge clk);
    slaveAck = 8'h02;
    @(negedge clk);
    slaveAck = 8'h00;
    idle_cycles(2);
    drive_req(3'd0, 1'b1, 1'b1, 8'h01, 2);
    @(negedge clk);
    reqIn = 1'b0;
    idle_cycles(20);

    // Test 5b: reqIn is held high while enable is low.
    // Nothing should start.
    cur       = 0;
    enable    = 1'b0;
    reqIn     = 1'b1;
    addressIn = 3'd1;
    repeat (4) begin
      @(negedge clk);
      check("disabled_dec", {24'd0, m_dec}, 32'd0);
      check("disabled_busy", {31'd0, m_busy}, 32'd0);
    end
    reqIn  = 1'b0;
    enable = 1'b1;
    idle_cycles(2);

    // enable dropping during ACCESS must not abort the transfer.
    drive_req(3'd4, 1'b0, 1'b0, 8'h10, 2);
    @(negedge clk);
    reqIn  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    slaveAck = 8'h10;
    @(negedge clk);
    slaveAck = 8'h00;
    @(negedge clk);
    enable = 1'b1;
    idle_cycles(20);

    // Test 6: reset is asserted two cycles into ACCESS.
    // No ack is expected for this request.
    cur = 0;
    @(negedge clk);
    reqIn     = 1'b1;
    addressIn = 3'd5;
    writeIn   = 1'b1;
    $display("txn cfg=%0d addr=5 wr=1 aborted by reset", cur);
    @(negedge clk);
    reqIn = 1'b0;
    @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    check("async_rst_dec", {24'd0, m_dec}, 32'd0);
    check("async_rst_wr", {31'd0, m_wr}, 32'd0);
    check("async_rst_busy", {31'd0, m_busy}, 32'd0);
    check("async_rst_ack", {31'd0, m_ack}, 32'd0);
    check("async_rst_err", {31'd0, m_err}, 32'd0);
    @(negedge clk);
    #2;
    resetN = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_busy", {31'd0, m_busy}, 32'd0);
      check("post_rst_ack", {31'd0, m_ack}, 32'd0);
    end

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
